// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, state type and entry layout for the trace recorder
package trace_pkg;

   // Trigger selection codes
   localparam logic [1:0] TRIG_IMM    = 2'd0;
   localparam logic [1:0] TRIG_PC     = 2'd1;
   localparam logic [1:0] TRIG_BRANCH = 2'd2;
   localparam logic [1:0] TRIG_INSTR  = 2'd3;

   // Capture/readout controller states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_POST,
      ST_DONE,
      ST_READ
   } state_e;

   // Entry layout, LSB first: branch, beq_offset, mem_chk, reg_chk, instr, pc
   localparam int BRANCH_LSB = 0;
   localparam int OFS_LSB    = 1;

   function automatic int mem_lsb(input int data_w, input int ofs_w);
      return ofs_w + 1 + 0 * data_w;
   endfunction

   function automatic int reg_lsb(input int data_w, input int ofs_w);
      return ofs_w + 1 + data_w;
   endfunction

   function automatic int instr_lsb(input int data_w, input int ofs_w);
      return ofs_w + 1 + 2 * data_w;
   endfunction

   function automatic int pc_lsb(input int data_w, input int ofs_w);
      return ofs_w + 1 + 3 * data_w;
   endfunction

   function automatic int entry_w(input int data_w, input int ofs_w);
      return 4 * data_w + ofs_w + 1;
   endfunction

endpackage

// File: rtl/trace_capture_if.sv
// rtl/trace_capture_if.sv - readout stream bundle between the recorder and its consumer
interface trace_capture_if
   import trace_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OFS_W  = 16
);
   localparam int ENTRY_W = entry_w(DATA_W, OFS_W);

   logic               rd_valid;
   logic               rd_ready;
   logic               rd_last;
   logic [ENTRY_W-1:0] rd_data;

   modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
   modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port sample buffer, synchronous write and synchronous read
module trace_ram #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 145
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: no reset so the array maps onto block RAM
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read port: output register only loads on re_i, so it holds during consumer stalls
   always_ff @(posedge clk) begin
      if (re_i) begin
         rdata_o <= mem_q[raddr_i];
      end
   end
endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - pre/post-trigger execution trace recorder with streamed readout
module trace_capture
   import trace_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int OFS_W     = 16,
   parameter int DEPTH     = 64,
   parameter int POST_TRIG = DEPTH / 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_en_i,
   input  logic [DATA_W-1:0]        pc_i,
   input  logic [DATA_W-1:0]        instr_i,
   input  logic [DATA_W-1:0]        reg_chk_i,
   input  logic [DATA_W-1:0]        mem_chk_i,
   input  logic                     branch_i,
   input  logic [OFS_W-1:0]         beq_offset_i,
   input  logic                     arm_i,
   input  logic                     abort_i,
   input  logic [1:0]               trig_mode_i,
   input  logic [DATA_W-1:0]        trig_val_i,
   input  logic                     rd_start_i,
   trace_capture_if.master          rd,
   output logic                     armed_o,
   output logic                     triggered_o,
   output logic                     done_o,
   output logic [$clog2(DEPTH)-1:0] trig_idx_o
);
   localparam int ENTRY_W = entry_w(DATA_W, OFS_W);
   localparam int AW      = $clog2(DEPTH);
   localparam int CW      = AW + 1;

   state_e             state_q,    state_d;
   logic [AW-1:0]      wr_ptr_q,   wr_ptr_d;
   logic               wrapped_q,  wrapped_d;
   logic [CW-1:0]      post_cnt_q, post_cnt_d;
   logic [AW-1:0]      trig_idx_q, trig_idx_d;
   logic [AW-1:0]      rd_addr_q,  rd_addr_d;
   logic [CW-1:0]      left_q,     left_d;
   logic               rd_valid_q, rd_valid_d;
   logic               rd_last_q,  rd_last_d;

   logic               trig_match;
   logic               trig_hit;
   logic               wr_en;
   logic               rd_en;
   logic [ENTRY_W-1:0] wr_data;
   logic [ENTRY_W-1:0] ram_rdata;

   // Pack the probe channels into one buffer entry, pc in the MSBs
   always_comb begin
      wr_data = '0;
      wr_data[pc_lsb(DATA_W, OFS_W)    +: DATA_W] = pc_i;
      wr_data[instr_lsb(DATA_W, OFS_W) +: DATA_W] = instr_i;
      wr_data[reg_lsb(DATA_W, OFS_W)   +: DATA_W] = reg_chk_i;
      wr_data[mem_lsb(DATA_W, OFS_W)   +: DATA_W] = mem_chk_i;
      wr_data[OFS_LSB                  +: OFS_W]  = beq_offset_i;
      wr_data[BRANCH_LSB]                         = branch_i;
   end

   // Trigger condition on the current sample; only meaningful for enabled samples in PRE
   always_comb begin
      trig_match = 1'b0;
      unique case (trig_mode_i)
         TRIG_IMM:    trig_match = 1'b1;
         TRIG_PC:     trig_match = (pc_i == trig_val_i);
         TRIG_BRANCH: trig_match = branch_i;
         TRIG_INSTR:  trig_match = (instr_i == trig_val_i);
      endcase
      trig_hit = (state_q == ST_PRE) && sample_en_i && trig_match;
   end

   // Next-state logic for capture, freeze and readout; abort overrides everything
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      wrapped_d  = wrapped_q;
      post_cnt_d = post_cnt_q;
      trig_idx_d = trig_idx_q;
      rd_addr_d  = rd_addr_q;
      left_d     = left_q;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;

      if (abort_i) begin
         state_d    = ST_IDLE;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (arm_i) begin
                  state_d    = ST_PRE;
                  wr_ptr_d   = '0;
                  wrapped_d  = 1'b0;
                  post_cnt_d = '0;
               end
            end
            ST_PRE: begin
               if (sample_en_i) begin
                  wr_en = 1'b1;
                  if (trig_hit) begin
                     trig_idx_d = wr_ptr_q;
                     post_cnt_d = CW'(1);
                     state_d    = (POST_TRIG == 1) ? ST_DONE : ST_POST;
                  end
               end
            end
            ST_POST: begin
               if (sample_en_i) begin
                  wr_en      = 1'b1;
                  post_cnt_d = post_cnt_q + 1'b1;
                  if (post_cnt_q + 1'b1 == CW'(POST_TRIG)) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (rd_start_i) begin
                  state_d   = ST_READ;
                  rd_addr_d = wrapped_q ? wr_ptr_q : '0;
                  left_d    = wrapped_q ? CW'(DEPTH) : {1'b0, wr_ptr_q};
               end
            end
            ST_READ: begin
               if (rd_valid_q && rd.rd_ready && rd_last_q) begin
                  state_d    = ST_IDLE;
                  rd_valid_d = 1'b0;
                  rd_last_d  = 1'b0;
               end else if (left_q != '0 && (!rd_valid_q || rd.rd_ready)) begin
                  // Fetch the next entry while the current one is being accepted
                  rd_en      = 1'b1;
                  rd_addr_d  = rd_addr_q + 1'b1;
                  left_d     = left_q - 1'b1;
                  rd_valid_d = 1'b1;
                  rd_last_d  = (left_q == CW'(1));
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (&wr_ptr_q) begin
               wrapped_d = 1'b1;
            end
         end
      end
   end

   // Controller registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         wrapped_q  <= 1'b0;
         post_cnt_q <= '0;
         trig_idx_q <= '0;
         rd_addr_q  <= '0;
         left_q     <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         wrapped_q  <= wrapped_d;
         post_cnt_q <= post_cnt_d;
         trig_idx_q <= trig_idx_d;
         rd_addr_q  <= rd_addr_d;
         left_q     <= left_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_en),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_data),
      .re_i    (rd_en),
      .raddr_i (rd_addr_q),
      .rdata_o (ram_rdata)
   );

   // RAM output is unreset; gating with rd_valid keeps rd_data at zero out of reset
   assign rd.rd_data  = rd_valid_q ? ram_rdata : '0;
   assign rd.rd_valid = rd_valid_q;
   assign rd.rd_last  = rd_last_q;

   assign armed_o     = (state_q == ST_PRE) || (state_q == ST_POST);
   assign triggered_o = (state_q == ST_POST) || (state_q == ST_DONE) || (state_q == ST_READ);
   assign done_o      = (state_q == ST_DONE);
   assign trig_idx_o  = trig_idx_q;
endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - randomized self-checking bench for trace_capture
module tb_trace_capture;
   import trace_pkg::*;

   localparam int DATA_W    = 32;
   localparam int OFS_W     = 16;
   localparam int DEPTH     = 8;
   localparam int POST_TRIG = 4;
   localparam int ENTRY_W   = 4 * DATA_W + OFS_W + 1;

   typedef logic [ENTRY_W-1:0] entry_t;
   typedef enum int {M_IDLE, M_PRE, M_POST, M_DONE, M_READ} mphase_e;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sample_en;
   logic [DATA_W-1:0] pc, instr, reg_chk, mem_chk, trig_val;
   logic              branch, arm, abort, rd_start;
   logic [OFS_W-1:0]  beq_offset;
   logic [1:0]        trig_mode;
   logic              armed, triggered, done;
   logic [2:0]        trig_idx;

   always #5 clk = ~clk;

   trace_capture_if #(.DATA_W(DATA_W), .OFS_W(OFS_W)) rd_if ();

   trace_capture #(
      .DATA_W(DATA_W), .OFS_W(OFS_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sample_en_i(sample_en),
      .pc_i(pc), .instr_i(instr), .reg_chk_i(reg_chk), .mem_chk_i(mem_chk),
      .branch_i(branch), .beq_offset_i(beq_offset),
      .arm_i(arm), .abort_i(abort), .trig_mode_i(trig_mode), .trig_val_i(trig_val),
      .rd_start_i(rd_start), .rd(rd_if),
      .armed_o(armed), .triggered_o(triggered), .done_o(done), .trig_idx_o(trig_idx)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input entry_t act, input entry_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic entry_t pack_e(input logic [31:0] p, i, r, m, input logic [15:0] o, input logic b);
      return {p, i, r, m, o, b};
   endfunction

   function automatic logic [31:0] pc_of(input entry_t e);
      return e[ENTRY_W-1 -: DATA_W];
   endfunction

   // Behavioural reference: history of every stored sample, readout = newest DEPTH of it
   mphase_e m_ph = M_IDLE;
   entry_t  hist[$];
   entry_t  exp_q[$];
   entry_t  got[$];
   int      m_trig_pos = 0;
   int      m_post = 0;
   int      m_age = 0;
   int      m_n;
   bit      hs_pend = 0;
   bit      m_hit;
   bit      stall_prev = 0;
   entry_t  stall_data;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_ph = M_IDLE;
         hist.delete();
         exp_q.delete();
         m_trig_pos = 0;
         hs_pend = 0;
      end else begin
         m_hit = (trig_mode == 2'd0) || (trig_mode == 2'd1 && pc == trig_val) ||
                 (trig_mode == 2'd2 && branch) || (trig_mode == 2'd3 && instr == trig_val);
         if (abort) begin
            m_ph = M_IDLE;
            exp_q.delete();
         end else begin
            case (m_ph)
               M_IDLE: if (arm) begin m_ph = M_PRE; hist.delete(); m_post = 0; end
               M_PRE: if (sample_en) begin
                  hist.push_back(pack_e(pc, instr, reg_chk, mem_chk, beq_offset, branch));
                  if (m_hit) begin
                     m_trig_pos = (hist.size() - 1) % DEPTH;
                     m_post = 1;
                     m_ph = (m_post == POST_TRIG) ? M_DONE : M_POST;
                  end
               end
               M_POST: if (sample_en) begin
                  hist.push_back(pack_e(pc, instr, reg_chk, mem_chk, beq_offset, branch));
                  m_post++;
                  if (m_post == POST_TRIG) m_ph = M_DONE;
               end
               M_DONE: if (rd_start) begin
                  m_ph = M_READ;
                  m_age = 0;
                  exp_q.delete();
                  m_n = (hist.size() < DEPTH) ? hist.size() : DEPTH;
                  for (int i = hist.size() - m_n; i < hist.size(); i++) exp_q.push_back(hist[i]);
               end
               M_READ: begin
                  m_age++;
                  if (hs_pend) begin
                     void'(exp_q.pop_front());
                     if (exp_q.size() == 0) m_ph = M_IDLE;
                  end
               end
               default: m_ph = M_IDLE;
            endcase
         end
         hs_pend = 0;
      end
   end

   // Per-cycle comparison against the reference, on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("armed", armed, (m_ph == M_PRE || m_ph == M_POST));
         chk("triggered", triggered, (m_ph == M_POST || m_ph == M_DONE || m_ph == M_READ));
         chk("done", done, (m_ph == M_DONE));
         chk("rd_valid", rd_if.rd_valid, (m_ph == M_READ && m_age >= 1 && exp_q.size() > 0));
         if (m_ph == M_POST || m_ph == M_DONE || m_ph == M_READ)
            chk("trig_idx", trig_idx, m_trig_pos);
         if (rd_if.rd_valid && exp_q.size() > 0) begin
            chk("rd_data", rd_if.rd_data, exp_q[0]);
            chk("rd_last", rd_if.rd_last, (exp_q.size() == 1));
            if (stall_prev) chk("stall_hold", rd_if.rd_data, stall_data);
         end
         if (rd_if.rd_valid && rd_if.rd_ready) begin
            hs_pend = 1;
            got.push_back(rd_if.rd_data);
         end
         stall_prev = rd_if.rd_valid && !rd_if.rd_ready;
         stall_data = rd_if.rd_data;
      end else begin
         stall_prev = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit en, input logic [31:0] p, i, input bit b, input logic [15:0] o);
      sample_en  = en;
      pc         = p;
      instr      = i;
      reg_chk    = $urandom;
      mem_chk    = $urandom;
      branch     = b;
      beq_offset = o;
   endtask

   task automatic do_arm(input logic [1:0] mode, input logic [31:0] tv);
      trig_mode = mode;
      trig_val  = tv;
      arm = 1'b1;
      cyc();
      arm = 1'b0;
   endtask

   // ready_mode: 0 always ready, 1 three-cycle stall mid-stream, 2 random
   task automatic read_out(input int ready_mode);
      bit fin;
      got.delete();
      rd_start = 1'b1;
      cyc();
      rd_start = 1'b0;
      fin = 0;
      for (int i = 0; i < 120 && !fin; i++) begin
         case (ready_mode)
            1: rd_if.rd_ready = !(i >= 3 && i < 6);
            2: rd_if.rd_ready = 1'($urandom_range(0, 1));
            default: rd_if.rd_ready = 1'b1;
         endcase
         cyc();
         if (m_ph == M_IDLE) fin = 1;
      end
      rd_if.rd_ready = 1'b0;
      n_vec++;
      if (!fin) begin
         n_err++;
         $display("FAIL read_timeout: readout still running, expected completion");
      end
   endtask

   task automatic feed_pc_ramp(input int n, input logic [31:0] base);
      for (int k = 0; k < n; k++) begin
         drive(1'b1, base + 32'(4 * k), 32'h1000_0000 + 32'(k), 1'b0, 16'(k));
         cyc();
      end
      sample_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      drive(1'b0, 0, 0, 1'b0, 0);
      arm = 0; abort = 0; rd_start = 0; trig_mode = 0; trig_val = 0;
      rd_if.rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_armed", armed, 0);
      chk("rst_triggered", triggered, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_valid", rd_if.rd_valid, 0);
      chk("rst_rd_last", rd_if.rd_last, 0);
      chk("rst_rd_data", rd_if.rd_data, 0);
      chk("rst_trig_idx", trig_idx, 0);
      rst_n = 1'b1;
      cyc();

      // Wrapped capture: trigger at pc 0x20, four post samples 0x20..0x2c
      do_arm(2'd1, 32'h20);
      feed_pc_ramp(17, 32'h0);
      chk("t1_done", done, 1);
      read_out(0);
      chk("t1_count", got.size(), 8);
      chk("t1_first_pc", pc_of(got[0]), 32'h10);
      chk("t1_last_pc", pc_of(got[7]), 32'h2c);
      chk("t1_trig_idx", trig_idx, 0);

      // Non-wrapped capture with a consumer stall mid-stream
      do_arm(2'd1, 32'h08);
      feed_pc_ramp(10, 32'h0);
      read_out(1);
      chk("t2_count", got.size(), 6);
      chk("t2_first_pc", pc_of(got[0]), 32'h00);
      chk("t2_last_pc", pc_of(got[5]), 32'h14);
      chk("t2_trig_idx", trig_idx, 2);

      // Branch trigger with sample_en toggling
      do_arm(2'd2, 32'h0);
      for (int k = 0; k < 20; k++) begin
         drive(k % 2 == 0, 32'(4 * k), 32'h2000_0000 + 32'(k), k == 6, 16'h1000 + 16'(k));
         cyc();
      end
      sample_en = 1'b0;
      branch = 1'b0;
      read_out(0);
      chk("t3_count", got.size(), 7);
      chk("t3_trig_pc", pc_of(got[3]), 32'h18);
      chk("t3_trig_branch", got[3][0], 1);
      chk("t3_trig_ofs", got[3][16:1], 16'h1006);
      chk("t3_trig_idx", trig_idx, 3);

      // Abort during POST after a wrap, then a fresh capture must not be wrapped
      do_arm(2'd1, 32'h500);
      feed_pc_ramp(10, 32'h100);
      drive(1'b1, 32'h500, 32'h0, 1'b0, 16'h0);
      cyc();
      drive(1'b1, 32'h504, 32'h0, 1'b0, 16'h0);
      cyc();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      sample_en = 1'b0;
      chk("t4_idle_armed", armed, 0);
      chk("t4_idle_triggered", triggered, 0);
      do_arm(2'd1, 32'h08);
      feed_pc_ramp(10, 32'h0);
      read_out(0);
      chk("t4_count", got.size(), 6);
      chk("t4_first_pc", pc_of(got[0]), 32'h00);

      // Randomized captures and readouts
      for (int r = 0; r < 10; r++) begin
         logic [1:0] mode;
         mode = 2'($urandom_range(0, 3));
         do_arm(mode, (mode == 2'd3) ? 32'($urandom_range(0, 3)) : 32'(4 * $urandom_range(0, 15)));
         for (int c = 0; c < 80 && m_ph != M_DONE; c++) begin
            drive($urandom_range(0, 9) < 7, 32'(4 * $urandom_range(0, 15)),
                  32'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, 16'($urandom));
            arm      = ($urandom_range(0, 9) == 0);
            rd_start = ($urandom_range(0, 9) == 0);
            cyc();
         end
         arm = 1'b0;
         rd_start = 1'b0;
         sample_en = 1'b0;
         if (m_ph != M_DONE) begin
            abort = 1'b1;
            cyc();
            abort = 1'b0;
         end else begin
            read_out(2);
         end
      end

      // Asynchronous reset in the middle of a readout
      do_arm(2'd0, 32'h0);
      feed_pc_ramp(6, 32'h40);
      rd_start = 1'b1;
      cyc();
      rd_start = 1'b0;
      rd_if.rd_ready = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b0;
      #2;
      chk("ar_rd_valid", rd_if.rd_valid, 0);
      chk("ar_rd_last", rd_if.rd_last, 0);
      chk("ar_rd_data", rd_if.rd_data, 0);
      chk("ar_armed", armed, 0);
      chk("ar_triggered", triggered, 0);
      chk("ar_done", done, 0);
      chk("ar_trig_idx", trig_idx, 0);
      rd_if.rd_ready = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      chk("post_rst_triggered", triggered, 0);
      chk("post_rst_rd_valid", rd_if.rd_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
